// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiplier for MUL, MLA, UMULL and SMULL with a start/busy/done handshake.
// Optional build macro MUL_EARLY_EXIT_EN ends RUN as soon as the remaining multiplier bits are zero.
module mul_iter_unit #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW    = $clog2(STEPS + 1);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULL = 2'b01;
    localparam logic [1:0] OP_SMULL = 2'b10;
    localparam logic [1:0] OP_MLA   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t           r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_acc_in;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic             r_neg;
    logic [PW-1:0]    r_prod;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_n;
    logic             r_z;

    logic             w_accept;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [PW-1:0]    w_partial;
    logic [WIDTH-1:0] w_mplier_nx;
    logic [CW-1:0]    w_cnt_nx;
    logic             w_run_last;
    logic [PW-1:0]    w_prod_fin;
    logic             w_long;
    logic [WIDTH-1:0] w_lo_fin;
    logic [WIDTH-1:0] w_hi_fin;
    logic             w_n_fin;
    logic             w_z_fin;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // SMULL runs on magnitudes; the sign is restored in FIN.
    assign w_a_neg = (op == OP_SMULL) && a[WIDTH-1];
    assign w_b_neg = (op == OP_SMULL) && b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~a + WIDTH'(1)) : a;
    assign w_b_mag = w_b_neg ? (~b + WIDTH'(1)) : b;

    // Sum of the pre-shifted multiplicand for each set bit in the current multiplier group.
    always_comb begin
        w_partial = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_mplier[i]) begin
                w_partial = w_partial + (r_mcand << i);
            end
        end
    end

    assign w_mplier_nx = r_mplier >> BITS_PER_CYCLE;
    assign w_cnt_nx    = r_cnt - CW'(1);

`ifdef MUL_EARLY_EXIT_EN
    assign w_run_last = (w_cnt_nx == '0) || (w_mplier_nx == '0);
`else
    assign w_run_last = (w_cnt_nx == '0);
`endif

    // Final sign fix-up, MLA addend and flag derivation.
    assign w_prod_fin = r_neg ? (~r_prod + PW'(1)) : r_prod;
    assign w_long     = (r_op == OP_UMULL) || (r_op == OP_SMULL);
    assign w_lo_fin   = (r_op == OP_MLA) ? (w_prod_fin[WIDTH-1:0] + r_acc_in)
                                         : w_prod_fin[WIDTH-1:0];
    assign w_hi_fin   = w_long ? w_prod_fin[PW-1:WIDTH] : '0;
    assign w_n_fin    = w_long ? w_hi_fin[WIDTH-1] : w_lo_fin[WIDTH-1];
    assign w_z_fin    = (w_lo_fin == '0) && (w_hi_fin == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_op     <= OP_MUL;
            r_acc_in <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_op     <= op;
                        r_acc_in <= acc;
                        r_mcand  <= PW'(w_a_mag);
                        r_mplier <= w_b_mag;
                        r_neg    <= w_a_neg ^ w_b_neg;
                        r_prod   <= '0;
                        r_cnt    <= CW'(STEPS);
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_prod   <= r_prod + w_partial;
                    r_mcand  <= r_mcand << BITS_PER_CYCLE;
                    r_mplier <= w_mplier_nx;
                    r_cnt    <= w_cnt_nx;
                    if (w_run_last) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_lo    <= w_lo_fin;
                    r_hi    <= w_hi_fin;
                    r_n     <= w_n_fin;
                    r_z     <= w_z_fin;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result_lo = r_lo;
    assign result_hi = r_hi;
    assign flag_n    = r_n;
    assign flag_z    = r_z;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Directed bench for mul_iter_unit: a default build and a 4-bits-per-cycle build side by side.
module tb_mul_iter_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        start4;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] acc;

    logic        busy1, done1, n1, z1;
    logic [31:0] lo1, hi1;
    logic        busy4, done4, n4, z4;
    logic [31:0] lo4, hi4;

    int n_tests;
    int n_fail;

    mul_iter_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .acc(acc),
        .busy(busy1), .done(done1), .result_lo(lo1), .result_hi(hi1),
        .flag_n(n1), .flag_z(z1)
    );

    mul_iter_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .op(op), .a(a), .b(b), .acc(acc),
        .busy(busy4), .done(done4), .result_lo(lo4), .result_hi(hi4),
        .flag_n(n4), .flag_z(z4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Edges from the accepting edge (counted as 1) to the edge after which done is seen.
    function automatic int lat_of(input logic [31:0] bmag, input int bpc);
        int g;
        g = 0;
`ifdef MUL_EARLY_EXIT_EN
        for (int i = 0; i < 32; i++) begin
            if (bmag[i]) g = i / bpc + 1;
        end
        if (g == 0) g = 1;
`else
        g = 32 / bpc;
        if (bmag == 32'hFFFF_FFFF) g = 32 / bpc;
`endif
        return g + 2;
    endfunction

    task automatic run_op(input string tag, input bit use4, input logic [1:0] t_op,
                          input logic [31:0] t_a, input logic [31:0] t_b, input logic [31:0] t_acc,
                          input logic [31:0] e_lo, input logic [31:0] e_hi,
                          input logic e_n, input logic e_z, input logic [31:0] b_mag);
        int n;
        int nb;
        int e_lat;
        e_lat = lat_of(b_mag, use4 ? 4 : 1);
        @(negedge clk);
        op = t_op; a = t_a; b = t_b; acc = t_acc;
        if (use4) start4 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; start4 = 1'b0;
        a = ~t_a; b = ~t_b; acc = ~t_acc;
        n  = 1;
        nb = 0;
        while (!(use4 ? done4 : done1) && n < 200) begin
            if (use4 ? busy4 : busy1) nb++;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ":latency"}, 64'(n), 64'(e_lat));
        check({tag, ":busy_cycles"}, 64'(nb), 64'(e_lat - 1));
        check({tag, ":lo"}, 64'(use4 ? lo4 : lo1), 64'(e_lo));
        check({tag, ":hi"}, 64'(use4 ? hi4 : hi1), 64'(e_hi));
        check({tag, ":n"}, 64'(use4 ? n4 : n1), 64'(e_n));
        check({tag, ":z"}, 64'(use4 ? z4 : z1), 64'(e_z));
        @(posedge clk);
        #1;
        check({tag, ":done_pulse"}, 64'(use4 ? done4 : done1), 64'd0);
        check({tag, ":lo_hold"}, 64'(use4 ? lo4 : lo1), 64'(e_lo));
    endtask

    initial begin
        int n;
        int nd;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0; start = 1'b0; start4 = 1'b0;
        op = 2'b00; a = '0; b = '0; acc = '0;
        #2;
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_done", 64'(done1), 64'd0);
        check("rst_lo", 64'(lo1), 64'd0);
        check("rst_hi", 64'(hi1), 64'd0);
        check("rst_flags", 64'({n1, z1}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        run_op("mul_7x6",       0, 2'b00, 32'd7,         32'd6,         32'd0, 32'd42,        32'd0,         1'b0, 1'b0, 32'd6);
        run_op("smull_m3x5",    0, 2'b10, 32'hFFFF_FFFD, 32'd5,         32'd0, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd5);
        run_op("smull_minmin",  0, 2'b10, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0,         32'h4000_0000, 1'b0, 1'b0, 32'h8000_0000);
        run_op("umull_max",     0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFF);
        run_op("mla_3x4p5",     0, 2'b11, 32'd3,         32'd4,         32'd5, 32'd17,        32'd0,         1'b0, 1'b0, 32'd4);
        run_op("mul_0x9",       0, 2'b00, 32'd0,         32'd9,         32'd0, 32'd0,         32'd0,         1'b0, 1'b1, 32'd9);
        run_op("smull_m1x0",    0, 2'b10, 32'hFFFF_FFFF, 32'd0,         32'd0, 32'd0,         32'd0,         1'b0, 1'b1, 32'd0);
        run_op("mla_wrap",      0, 2'b11, 32'hFFFF_FFFF, 32'd1,         32'd2, 32'd1,         32'd0,         1'b0, 1'b0, 32'd1);
        run_op("umull_carry",   0, 2'b01, 32'h8000_0000, 32'd2,         32'd0, 32'd0,         32'd1,         1'b0, 1'b0, 32'd2);
        run_op("mul_neg",       0, 2'b00, 32'hFFFF_FFFF, 32'd2,         32'd0, 32'hFFFF_FFFE, 32'd0,         1'b1, 1'b0, 32'd2);
        run_op("b4_mul_7x6",    1, 2'b00, 32'd7,         32'd6,         32'd0, 32'd42,        32'd0,         1'b0, 1'b0, 32'd6);
        run_op("b4_umull_max",  1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFF);
        run_op("b4_smull_m3x5", 1, 2'b10, 32'hFFFF_FFFD, 32'd5,         32'd0, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd5);

        // start held high while operands wander during RUN, then re-issued in the DONE cycle
        @(negedge clk);
        op = 2'b00; a = 32'd2; b = 32'd3; acc = 32'd0; start = 1'b1;
        @(posedge clk);
        #1;
        a = $urandom; b = $urandom;
        n  = 1;
        nd = 0;
        while (!done1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (done1) nd++;
            else begin a = $urandom; b = $urandom; end
        end
        check("hold_latency", 64'(n), 64'(lat_of(32'd3, 1)));
        check("hold_one_done", 64'(nd), 64'd1);
        check("hold_lo", 64'(lo1), 64'd6);
        a = 32'd4; b = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("redone_busy", 64'(busy1), 64'd1);
        check("redone_done_low", 64'(done1), 64'd0);
        n = 1;
        while (!done1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("redone_latency", 64'(n), 64'(lat_of(32'd5, 1)));
        check("redone_lo", 64'(lo1), 64'd20);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        op = 2'b00; a = 32'd9; b = 32'h8000_0001; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        check("abort_busy_before", 64'(busy1), 64'd1);
        reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy1), 64'd0);
        check("abort_done", 64'(done1), 64'd0);
        check("abort_lo", 64'(lo1), 64'd0);
        check("abort_hi", 64'(hi1), 64'd0);
        check("abort_flags", 64'({n1, z1}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done1) nd++;
        end
        check("abort_no_done", 64'(nd), 64'd0);
        run_op("post_rst_5x5", 0, 2'b00, 32'd5, 32'd5, 32'd0, 32'd25, 32'd0, 1'b0, 1'b0, 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
